// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stage stall requests, raises flush/redirect on MEM exceptions.
// Optional stall watchdog is enabled by defining PIPELINE_CTRL_TIMEOUT_EN.
module pipeline_ctrl #(
   parameter logic [31:0] INT_VECTOR   = 32'h00000020,
   parameter logic [31:0] EXC_VECTOR   = 32'h00000040,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned TIMEOUT      = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   input  logic        clr_cnt,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        stall_timeout
);

   localparam logic [31:0] EretCode = 32'h0000000e;
   localparam logic [31:0] IntCode  = 32'h00000001;

   if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 15 || TIMEOUT == 0) begin : g_bad_param
      $error("pipeline_ctrl: FLUSH_CYCLES must be 1..15 and TIMEOUT non-zero");
   end

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e      state_q;
   logic [3:0]  drain_q;
   logic [31:0] latched_pc_q;
   logic        accept;

   assign accept = (state_q == StRun) && (excepttype != 32'h0);

   always_comb begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h0;
      if (!rst) begin
         if (state_q == StDrain) begin
            flush  = 1'b1;
            new_pc = latched_pc_q;
         end else if (accept) begin
            flush = 1'b1;
            if (excepttype == EretCode)     new_pc = cp0_epc;
            else if (excepttype == IntCode) new_pc = INT_VECTOR;
            else                            new_pc = EXC_VECTOR;
         end else if (stallreq_mem) begin
            stall = 6'b011111;
         end else if (stallreq_ex) begin
            stall = 6'b001111;
         end else if (stallreq_id || stallreq_if) begin
            stall = 6'b000111;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRun;
         drain_q      <= 4'd0;
         latched_pc_q <= 32'h0;
         stall_cnt    <= 32'h0;
         flush_cnt    <= 16'h0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (accept) begin
                  latched_pc_q <= new_pc;
                  if (FLUSH_CYCLES > 1) begin
                     state_q <= StDrain;
                     drain_q <= 4'(FLUSH_CYCLES - 1);
                  end
               end
            end
            StDrain: begin
               drain_q <= drain_q - 4'd1;
               if (drain_q == 4'd1) state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase

         if (clr_cnt) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 16'h0;
         end else begin
            if (stall[0] && (stall_cnt != 32'hFFFFFFFF)) stall_cnt <= stall_cnt + 32'd1;
            if (accept && (flush_cnt != 16'hFFFF))       flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end

`ifdef PIPELINE_CTRL_TIMEOUT_EN
   localparam logic [15:0] TimeoutLim = 16'(TIMEOUT);

   logic [15:0] run_len_q, run_len_d;
   logic        timeout_q;

   // Length of the current uninterrupted PC stall, saturating.
   always_comb begin
      run_len_d = 16'h0;
      if (stall[0]) run_len_d = (run_len_q == 16'hFFFF) ? run_len_q : run_len_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_len_q <= 16'h0;
         timeout_q <= 1'b0;
      end else begin
         run_len_q <= run_len_d;
         if (clr_cnt)                       timeout_q <= 1'b0;
         else if (run_len_d >= TimeoutLim)  timeout_q <= 1'b1;
      end
   end

   assign stall_timeout = timeout_q;
`else
   assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (FLUSH_CYCLES 1 and 3) against a behavioural model.
module tb_pipeline_ctrl;
   localparam int unsigned Tmo = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        sif, sid, sex, smem, clr;
   logic [31:0] exc, epc;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b, to_a, to_b;
   logic [31:0] pc_a, pc_b, scnt_a, scnt_b;
   logic [15:0] fcnt_a, fcnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(Tmo)) dut_a (
      .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
      .stallreq_mem(smem), .excepttype(exc), .cp0_epc(epc), .clr_cnt(clr),
      .stall(stall_a), .flush(flush_a), .new_pc(pc_a), .stall_cnt(scnt_a),
      .flush_cnt(fcnt_a), .stall_timeout(to_a));

   pipeline_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(Tmo)) dut_b (
      .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
      .stallreq_mem(smem), .excepttype(exc), .cp0_epc(epc), .clr_cnt(clr),
      .stall(stall_b), .flush(flush_b), .new_pc(pc_b), .stall_cnt(scnt_b),
      .flush_cnt(fcnt_b), .stall_timeout(to_b));

   // Model state: remaining flush cycles after the accepting one, latched target, counters.
   int          m_drain[2];
   logic [31:0] m_lpc[2];
   longint      m_scnt[2];
   int          m_fcnt[2];
   int          m_run[2];
   bit          m_to[2];
   logic [5:0]  e_stall[2];
   bit          e_flush[2];
   logic [31:0] e_pc[2];

   function automatic int fc(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] target(logic [31:0] code, logic [31:0] pc);
      if (code == 32'he) return pc;
      if (code == 32'h1) return 32'h20;
      return 32'h40;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_drain[i] = 0; m_lpc[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0; m_run[i] = 0; m_to[i] = 0;
      end
   endtask

   task automatic model_comb();
      int n;
      for (int i = 0; i < 2; i++) begin
         e_stall[i] = 6'b0; e_flush[i] = 0; e_pc[i] = 32'h0;
         if (rst) continue;
         if (m_drain[i] > 0) begin
            e_flush[i] = 1; e_pc[i] = m_lpc[i];
         end else if (exc != 0) begin
            e_flush[i] = 1; e_pc[i] = target(exc, epc);
         end else begin
            // Number of stalled stages counted from the PC upward.
            n = smem ? 5 : sex ? 4 : (sid || sif) ? 3 : 0;
            e_stall[i] = 6'((1 << n) - 1);
         end
      end
   endtask

   task automatic model_edge();
      bit acc, s0;
      model_comb();
      for (int i = 0; i < 2; i++) begin
         s0  = e_stall[i][0];
         acc = (m_drain[i] == 0) && (exc != 0);
         if (m_drain[i] > 0) m_drain[i]--;
         else if (acc) begin
            m_lpc[i]   = target(exc, epc);
            m_drain[i] = fc(i) - 1;
         end
         if (clr) begin
            m_scnt[i] = 0; m_fcnt[i] = 0;
         end else begin
            if (s0 && m_scnt[i] < 64'hFFFFFFFF) m_scnt[i]++;
            if (acc && m_fcnt[i] < 65535) m_fcnt[i]++;
         end
`ifdef PIPELINE_CTRL_TIMEOUT_EN
         m_run[i] = s0 ? ((m_run[i] < 65535) ? m_run[i] + 1 : m_run[i]) : 0;
         if (clr) m_to[i] = 0;
         else if (m_run[i] >= Tmo) m_to[i] = 1;
`endif
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      model_comb();
      chk("a.stall", 32'(stall_a), 32'(e_stall[0]));
      chk("b.stall", 32'(stall_b), 32'(e_stall[1]));
      chk("a.flush", 32'(flush_a), 32'(e_flush[0]));
      chk("b.flush", 32'(flush_b), 32'(e_flush[1]));
      chk("a.new_pc", pc_a, e_pc[0]);
      chk("b.new_pc", pc_b, e_pc[1]);
      chk("a.stall_cnt", scnt_a, 32'(m_scnt[0]));
      chk("b.stall_cnt", scnt_b, 32'(m_scnt[1]));
      chk("a.flush_cnt", 32'(fcnt_a), 32'(m_fcnt[0]));
      chk("b.flush_cnt", 32'(fcnt_b), 32'(m_fcnt[1]));
      chk("a.timeout", 32'(to_a), 32'(m_to[0]));
      chk("b.timeout", 32'(to_b), 32'(m_to[1]));
   endtask

   task automatic drive(bit f, bit d, bit e, bit m, logic [31:0] x, logic [31:0] pc, bit c);
      sif = f; sid = d; sex = e; smem = m; exc = x; epc = pc; clr = c;
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic settle();
      #1 check_all();
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      model_reset();
      @(negedge clk);
      settle();
      chk("rst.stall", 32'(stall_b), 32'h0);
      chk("rst.new_pc", pc_a, 32'h0);
      rst = 1'b0;
      settle();
      advance();

      // ex+id for three cycles, then mem alone.
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 1, 0, 32'h0, 32'h0, 0);
         settle();
         chk("exid.stall", 32'(stall_a), 32'h0f);
         advance();
      end
      drive(0, 0, 0, 1, 32'h0, 32'h0, 0);
      settle();
      chk("exid.stall_cnt", scnt_a, 32'd3);
      chk("mem.stall", 32'(stall_a), 32'h1f);
      advance();

      // Exception with competing mem stall, single-cycle flush.
      drive(0, 0, 0, 1, 32'h8, 32'h0, 0);
      settle();
      chk("exc.flush", 32'(flush_a), 32'h1);
      chk("exc.stall", 32'(stall_a), 32'h0);
      chk("exc.new_pc", pc_a, 32'h40);
      advance();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      settle();
      chk("exc.flush_next", 32'(flush_a), 32'h0);
      chk("exc.flush_cnt", 32'(fcnt_a), 32'h1);
      advance();
      advance();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
      settle();
      advance();

      // ERET on the three-cycle instance; a second exception mid-drain is ignored.
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, k == 1, (k == 0) ? 32'he : (k == 1) ? 32'h8 : 32'h0, 32'h1234, 0);
         settle();
         chk("eret.flush", 32'(flush_b), 32'h1);
         chk("eret.new_pc", pc_b, 32'h1234);
         advance();
      end
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      settle();
      chk("eret.flush_end", 32'(flush_b), 32'h0);
      chk("eret.flush_cnt", 32'(fcnt_b), 32'h1);
      advance();

      // Asynchronous reset in the middle of a drain.
      drive(0, 0, 0, 0, 32'h8, 32'h0, 0);
      settle();
      advance();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      settle();
      chk("mid.flush_before", 32'(flush_b), 32'h1);
      #1 rst = 1'b1;
      model_reset();
      #1 check_all();
      chk("mid.flush_rst", 32'(flush_b), 32'h0);
      chk("mid.new_pc_rst", pc_b, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 32'h1, 32'h0, 0);
      settle();
      chk("mid.new_exc_flush", 32'(flush_b), 32'h1);
      chk("mid.new_exc_pc", pc_b, 32'h20);
      advance();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
         settle();
         advance();
      end

`ifdef PIPELINE_CTRL_TIMEOUT_EN
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
         settle();
         advance();
      end
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      settle();
      chk("tmo.set", 32'(to_a), 32'h1);
      advance();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
      settle();
      chk("tmo.sticky", 32'(to_a), 32'h1);
      advance();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
      settle();
      chk("tmo.clr", 32'(to_a), 32'h0);
      chk("tmo.clr_cnt", scnt_a, 32'h0);
      advance();
`endif

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] x;
         if ($urandom_range(99) == 0) begin
            rst = 1'b1;
            model_reset();
            settle();
            @(negedge clk);
            rst = 1'b0;
            continue;
         end
         x = 32'h0;
         if ($urandom_range(9) == 0) begin
            case ($urandom_range(2))
               0:       x = 32'h1;
               1:       x = 32'he;
               default: x = $urandom | 32'h100;
            endcase
         end
         drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
               $urandom_range(5) == 0, x, $urandom, $urandom_range(29) == 0);
         settle();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
